// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK drive sequencer: command encodings, FSM state
// type, and the JK next-state rule used by the optional q checker.
package jk_seq_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

  // Value a JK flip-flop takes on the next edge given its current q and {j,k}.
  function automatic logic jk_next_q(input logic q, input logic [1:0] jk);
    logic r;
    case (jk)
      JK_CLR:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO (DEPTH x W) for the JK drive sequencer. The head entry is read
// combinationally so the sequencer can pop back-to-back without a bubble.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset; validity is tracked solely by count_reg.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are log2(DEPTH) wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/jk_drive_sequencer.sv
// Sequences queued {j,k} commands onto a downstream JK flip-flop, each held for
// cmd_len+1 enabled steps. Optional q checker compiled in with JK_SEQ_CHECK_EN.
module jk_drive_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_jk,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             step_en,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic [7:0]       cnt_issued,
  input  logic             q_in,
  output logic             mismatch
);

  localparam int ENT_W = 2 + LEN_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [ENT_W-1:0] head;
  logic [1:0]       head_jk;
  logic [LEN_W-1:0] head_len;

  seq_state_t       state_reg, state_next;
  logic [1:0]       jk_reg, jk_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [7:0]       cnt_reg, cnt_next;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign head_jk   = head[ENT_W-1 -: 2];
  assign head_len  = head[LEN_W-1:0];

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cmd_jk, cmd_len}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      jk_reg        <= JK_HOLD;
      remaining_reg <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      jk_reg        <= jk_next;
      remaining_reg <= remaining_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    jk_next        = jk_reg;
    remaining_next = remaining_reg;
    fifo_pop       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        jk_next = JK_HOLD;
        if (step_en && !fifo_empty) begin
          fifo_pop       = 1'b1;
          jk_next        = head_jk;
          remaining_next = head_len;
          state_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (step_en) begin
          if (remaining_reg != '0) begin
            remaining_next = remaining_reg - LEN_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next command so the drive has no 00 gap.
            fifo_pop       = 1'b1;
            jk_next        = head_jk;
            remaining_next = head_len;
          end else begin
            jk_next    = JK_HOLD;
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        jk_next    = JK_HOLD;
        state_next = ST_IDLE;
      end
    endcase
    cnt_next = fifo_pop ? cnt_reg + 8'd1 : cnt_reg;
  end

  assign j          = jk_reg[1];
  assign k          = jk_reg[0];
  assign busy       = (state_reg == ST_ISSUE) || !fifo_empty;
  assign cnt_issued = cnt_reg;

`ifdef JK_SEQ_CHECK_EN
  logic armed_reg;
  logic exp_q_reg;
  logic mismatch_reg;

  // Arms on the first definite drive (CLR/SET); q before that is unknown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_reg    <= 1'b0;
      exp_q_reg    <= 1'b0;
      mismatch_reg <= 1'b0;
    end else if (!armed_reg) begin
      if (jk_reg == JK_CLR || jk_reg == JK_SET) begin
        armed_reg <= 1'b1;
        exp_q_reg <= jk_reg[1];
      end
    end else begin
      if (q_in != exp_q_reg) begin
        mismatch_reg <= 1'b1;
      end
      exp_q_reg <= jk_next_q(exp_q_reg, jk_reg);
    end
  end

  assign mismatch = mismatch_reg;
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Self-checking bench for jk_drive_sequencer: directed scenarios plus a random
// run compared against a queue-based reference model; q_in comes from a JK FF.
module tb_jk_drive_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 3;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

`ifdef JK_SEQ_CHECK_EN
  localparam logic EXP_MISMATCH = 1'b1;
`else
  localparam logic EXP_MISMATCH = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_jk = 2'b00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             step_en = 1'b0;
  logic             j, k, busy, mismatch;
  logic [7:0]       cnt_issued;
  logic             q_in;
  logic             q_ff = 1'b0;
  logic             corrupt = 1'b0;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_drive_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_jk     (cmd_jk),
    .cmd_len    (cmd_len),
    .step_en    (step_en),
    .j          (j),
    .k          (k),
    .busy       (busy),
    .cnt_issued (cnt_issued),
    .q_in       (q_in),
    .mismatch   (mismatch)
  );

  // Downstream JK flip-flop, optionally corrupted on its way back to q_in.
  always @(posedge clk) begin
    case ({j, k})
      CLR:     q_ff <= 1'b0;
      SET:     q_ff <= 1'b1;
      TGL:     q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end
  assign q_in = q_ff ^ corrupt;

  // Reference model: a queue of commands and a count of drive steps left for
  // the command currently on the outputs (0 = nothing driven).
  typedef struct packed {
    logic [1:0]       jk;
    logic [LEN_W-1:0] len;
  } cmd_t;

  cmd_t       mq[$];
  cmd_t       m_cur;
  int         m_steps = 0;
  logic [1:0] m_jk = 2'b00;
  int         m_issued = 0;
  bit         m_can_push;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_steps  = 0;
      m_jk     = HOLD;
      m_issued = 0;
    end else begin
      m_can_push = cmd_valid && (mq.size() < DEPTH);
      if (step_en) begin
        if (m_steps > 1) begin
          m_steps = m_steps - 1;
        end else if (mq.size() > 0) begin
          m_cur    = mq.pop_front();
          m_jk     = m_cur.jk;
          m_steps  = int'(m_cur.len) + 1;
          m_issued = m_issued + 1;
        end else begin
          m_steps = 0;
          m_jk    = HOLD;
        end
      end
      if (m_can_push) mq.push_back('{jk: cmd_jk, len: cmd_len});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cmd_valid = 1'b0;
    step_en = 1'b0;
    corrupt = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests++; if ({j, k} !== HOLD) begin errors++; $display("FAIL reset_jk: got %b want 00", {j, k}); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    tests++; if (cnt_issued !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_issued); end
    tests++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
    reset = 1'b1;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single();
    int ones = 0;
    do_reset();
    step_en = 1'b1;
    cmd_valid = 1'b1; cmd_jk = SET; cmd_len = 3'd0;
    tick();
    cmd_valid = 1'b0;
    tests++; if ({j, k} !== HOLD) begin errors++; $display("FAIL single_latency: got %b want 00", {j, k}); end
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    tests++; if ({j, k} !== SET) begin errors++; $display("FAIL single_first: got %b want 10", {j, k}); end
    for (int i = 0; i < 4; i++) begin
      if ({j, k} == SET) ones++;
      tick();
    end
    tests++; if (ones !== 1) begin errors++; $display("FAIL single_width: got %0d cycles want 1", ones); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy %b want 0", busy); end
    tests++; if (cnt_issued !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt_issued); end
    $display("[TB] test_single done");
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [5];
    want[0] = TGL; want[1] = TGL; want[2] = TGL; want[3] = CLR; want[4] = HOLD;
    do_reset();
    step_en = 1'b1;
    cmd_valid = 1'b1; cmd_jk = TGL; cmd_len = 3'd2;
    tick();
    cmd_jk = CLR; cmd_len = 3'd0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({j, k} !== want[i]) begin errors++; $display("FAIL b2b_seq[%0d]: got %b want %b", i, {j, k}, want[i]); end
      tick();
    end
    tests++; if (cnt_issued !== 8'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", cnt_issued); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_full();
    logic [1:0] seq [5];
    seq[0] = SET; seq[1] = CLR; seq[2] = TGL; seq[3] = SET; seq[4] = CLR;
    do_reset();
    step_en = 1'b0;
    cmd_valid = 1'b1; cmd_len = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cmd_jk = seq[i];
      tick();
    end
    tests++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    cmd_jk = seq[4];
    tick(); tick(); tick();
    tests++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", cmd_ready); end
    step_en = 1'b1;
    tick();
    tests++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_release: got %b want 1", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({j, k} !== seq[i]) begin errors++; $display("FAIL full_order[%0d]: got %b want %b", i, {j, k}, seq[i]); end
      tick();
      cmd_valid = 1'b0;
    end
    tests++; if (cnt_issued !== 8'd5) begin errors++; $display("FAIL full_cnt: got %0d want 5", cnt_issued); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL full_drain: busy %b want 0", busy); end
    $display("[TB] test_full done");
  endtask

  task automatic test_stall();
    int tgl = 0;
    do_reset();
    step_en = 1'b1;
    cmd_valid = 1'b1; cmd_jk = TGL; cmd_len = 3'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step_en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      tick();
      if ({j, k} == TGL) tgl++;
    end
    tests++; if (tgl !== 6) begin errors++; $display("FAIL stall_width: got %0d cycles want 6", tgl); end
    $display("[TB] test_stall done");
  endtask

  task automatic test_reset_mid();
    int driven = 0;
    do_reset();
    step_en = 1'b1;
    cmd_valid = 1'b1; cmd_jk = TGL; cmd_len = 3'd3;
    tick();
    cmd_jk = SET; cmd_len = 3'd0;
    tick(); tick(); tick();
    cmd_valid = 1'b0;
    tests++; if ({j, k} !== TGL) begin errors++; $display("FAIL mid_active: got %b want 11", {j, k}); end
    reset = 1'b0;
    #1;
    tests++; if ({j, k} !== HOLD) begin errors++; $display("FAIL mid_jk: got %b want 00", {j, k}); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_empty: busy %b want 0", busy); end
    tests++; if (cnt_issued !== 8'd0) begin errors++; $display("FAIL mid_cnt: got %0d want 0", cnt_issued); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if ({j, k} != HOLD) driven++;
    end
    tests++; if (driven !== 0) begin errors++; $display("FAIL mid_stale: %0d driven cycles want 0", driven); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_jk    = 2'($urandom_range(0, 3));
      cmd_len   = LEN_W'($urandom_range(0, 7));
      step_en   = ($urandom_range(0, 3) != 0);
      tick();
      tests++; if ({j, k} !== m_jk) begin errors++; $display("FAIL rnd_jk @%0d: got %b want %b", i, {j, k}, m_jk); end
      tests++; if (busy !== (m_steps > 0 || mq.size() > 0)) begin errors++; $display("FAIL rnd_busy @%0d: got %b", i, busy); end
      tests++; if (cmd_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready @%0d: got %b want %b", i, cmd_ready, mq.size() < DEPTH); end
      tests++; if (cnt_issued !== 8'(m_issued)) begin errors++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, cnt_issued, 8'(m_issued)); end
      tests++; if (mismatch !== 1'b0) begin errors++; $display("FAIL rnd_mismatch @%0d: got %b want 0", i, mismatch); end
    end
    cmd_valid = 1'b0;
    $display("[TB] test_random done, %0d issued", m_issued);
  endtask

  task automatic test_checker();
    do_reset();
    step_en = 1'b1;
    cmd_valid = 1'b1; cmd_jk = SET; cmd_len = 3'd0;
    tick();
    cmd_jk = TGL; cmd_len = 3'd1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests++; if (mismatch !== 1'b0) begin errors++; $display("FAIL chk_clean: got %b want 0", mismatch); end
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    tick();
    tests++; if (mismatch !== EXP_MISMATCH) begin errors++; $display("FAIL chk_flag: got %b want %b", mismatch, EXP_MISMATCH); end
    tick(); tick(); tick();
    tests++; if (mismatch !== EXP_MISMATCH) begin errors++; $display("FAIL chk_sticky: got %b want %b", mismatch, EXP_MISMATCH); end
    $display("[TB] test_checker done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_stall();
    test_reset_mid();
    test_random();
    test_checker();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
